// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: instruction encodings (opcode / funct),
// execute-side enums (ALU op, functional unit, branch condition, memory size)
// and the decoded bundle handed from decode to execute/memory/writeback.
package decode_stage_pkg;

    localparam int         WIDTH  = 32;      // datapath / PC / immediate width
    localparam logic [4:0] REG_RA = 5'd31;   // link register written by JAL

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_BLEZ  = 6'h06,
        OP_BGTZ  = 6'h07,
        OP_ADDI  = 6'h08,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LLO   = 6'h18,
        OP_LHI   = 6'h19,
        OP_TRAP  = 6'h1A,
        OP_LB    = 6'h20,
        OP_LH    = 6'h21,
        OP_LW    = 6'h23,
        OP_LBU   = 6'h24,
        OP_LHU   = 6'h25,
        OP_SB    = 6'h28,
        OP_SH    = 6'h29,
        OP_SW    = 6'h2B
    } opcode_type;

    typedef enum logic [5:0] {
        F_SLL   = 6'h00,
        F_SRL   = 6'h02,
        F_SRA   = 6'h03,
        F_SLLV  = 6'h04,
        F_SRLV  = 6'h06,
        F_SRAV  = 6'h07,
        F_JR    = 6'h08,
        F_JALR  = 6'h09,
        F_MFHI  = 6'h10,
        F_MTHI  = 6'h11,
        F_MFLO  = 6'h12,
        F_MTLO  = 6'h13,
        F_MULT  = 6'h18,
        F_MULTU = 6'h19,
        F_DIV   = 6'h1A,
        F_DIVU  = 6'h1B,
        F_ADD   = 6'h20,
        F_ADDU  = 6'h21,
        F_SUB   = 6'h22,
        F_SUBU  = 6'h23,
        F_AND   = 6'h24,
        F_OR    = 6'h25,
        F_XOR   = 6'h26,
        F_NOR   = 6'h27,
        F_SLT   = 6'h2A,
        F_SLTU  = 6'h2B
    } funct_type;

    // ALU_AND is encoded as zero so an all-zero bundle is a valid idle value.
    typedef enum logic [2:0] {
        ALU_AND  = 3'd0,
        ALU_OR   = 3'd1,
        ALU_ADD  = 3'd2,
        ALU_SUB  = 3'd3,
        ALU_SLT  = 3'd4,
        ALU_SLTU = 3'd5,
        ALU_NOR  = 3'd6
    } alu_type;

    typedef enum logic [2:0] {
        UNIT_ALU     = 3'd0,
        UNIT_SHIFT   = 3'd1,
        UNIT_MULDIV  = 3'd2,
        UNIT_XOR     = 3'd3,
        UNIT_LOADIMM = 3'd4
    } unit_type;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_GTZ  = 3'd3,
        BR_LEZ  = 3'd4
    } br_cond_type;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_type;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       dest;
        logic [4:0]       shamt;
        logic [5:0]       funct;
        logic [WIDTH-1:0] imm;
        logic [25:0]      jtarget;
        unit_type         unit;
        alu_type          alu_op;
        logic             alu_src_imm;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        mem_size_type     mem_size;
        logic             mem_unsigned;
        br_cond_type      br_cond;
        logic             jump;
        logic             jump_reg;
        logic             link;
        logic             lhi;
        logic             illegal;
        logic             trap;
    } decoded_type;

endpackage

// File: rtl/decode_stage_if.sv
// Handshake bundle around the decode stage.
//   flush                 : squash everything held or arriving this cycle
//   in_valid/in_ready     : upstream instruction handshake
//   in_instr/in_pc        : raw 32-bit instruction word and its PC
//   out_valid/out_ready   : downstream handshake for the decoded bundle
//   out_dec               : registered decoded bundle
// master = the surrounding pipeline (fetch + execute side), slave = decode_stage.
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [WIDTH-1:0] in_pc;
    logic             out_valid;
    logic             out_ready;
    decoded_type      out_dec;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_dec
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_dec
    );

endinterface

// File: rtl/decode_stage_instr_decode_logic.sv
// Purely combinational instruction decoder: raw instruction word + PC in,
// decoded_type bundle out.
//   instr_i : 32-bit instruction word
//   pc_i    : PC of that instruction (passed through)
//   dec_o   : decoded control bundle
module instr_decode_logic
    import decode_stage_pkg::*;
(
    input  logic [31:0]      instr_i,
    input  logic [WIDTH-1:0] pc_i,
    output decoded_type      dec_o
);

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] imm_zext;
    logic             wr_en;
    logic             is_load;
    logic             is_store;
    logic             imm_form;   // result written to rt, operand B is imm

    assign opcode   = instr_i[31:26];
    assign funct    = instr_i[5:0];
    assign imm_sext = {{(WIDTH-16){instr_i[15]}}, instr_i[15:0]};
    assign imm_zext = {{(WIDTH-16){1'b0}}, instr_i[15:0]};

    always_comb begin
        dec_o       = '0;
        wr_en       = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        imm_form    = 1'b0;
        dec_o.pc    = pc_i;
        dec_o.rs    = instr_i[25:21];
        dec_o.rt    = instr_i[20:16];
        dec_o.shamt = instr_i[10:6];
        dec_o.funct = funct;

        case (opcode)
            OP_RTYPE: begin
                dec_o.dest = instr_i[15:11];
                wr_en      = 1'b1;
                case (funct)
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV:
                        dec_o.unit = UNIT_SHIFT;
                    F_JR: begin
                        dec_o.jump_reg = 1'b1;
                        wr_en          = 1'b0;
                    end
                    F_JALR: begin
                        dec_o.jump_reg = 1'b1;
                        dec_o.link     = 1'b1;
                    end
                    F_MFHI, F_MFLO:
                        dec_o.unit = UNIT_MULDIV;
                    F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        // HI/LO writers never touch the register file
                        dec_o.unit = UNIT_MULDIV;
                        wr_en      = 1'b0;
                    end
                    F_ADD, F_ADDU: dec_o.alu_op = ALU_ADD;
                    F_SUB, F_SUBU: dec_o.alu_op = ALU_SUB;
                    F_AND:         dec_o.alu_op = ALU_AND;
                    F_OR:          dec_o.alu_op = ALU_OR;
                    F_XOR:         dec_o.unit   = UNIT_XOR;
                    F_NOR:         dec_o.alu_op = ALU_NOR;
                    F_SLT:         dec_o.alu_op = ALU_SLT;
                    F_SLTU:        dec_o.alu_op = ALU_SLTU;
                    default:       dec_o.illegal = 1'b1;
                endcase
            end
            OP_J: begin
                dec_o.jump    = 1'b1;
                dec_o.jtarget = instr_i[25:0];
            end
            OP_JAL: begin
                dec_o.jump    = 1'b1;
                dec_o.link    = 1'b1;
                dec_o.jtarget = instr_i[25:0];
                dec_o.dest    = REG_RA;
                wr_en         = 1'b1;
            end
            OP_BEQ: begin
                dec_o.br_cond = BR_EQ;
                dec_o.alu_op  = ALU_SUB;
                dec_o.imm     = imm_sext;
            end
            OP_BNE: begin
                dec_o.br_cond = BR_NE;
                dec_o.alu_op  = ALU_SUB;
                dec_o.imm     = imm_sext;
            end
            OP_BLEZ: begin
                dec_o.br_cond = BR_LEZ;
                dec_o.imm     = imm_sext;
            end
            OP_BGTZ: begin
                dec_o.br_cond = BR_GTZ;
                dec_o.imm     = imm_sext;
            end
            OP_ADDI: begin
                imm_form     = 1'b1;
                dec_o.alu_op = ALU_ADD;
                dec_o.imm    = imm_sext;
            end
            OP_SLTI: begin
                imm_form     = 1'b1;
                dec_o.alu_op = ALU_SLT;
                dec_o.imm    = imm_sext;
            end
            OP_ANDI: begin
                imm_form     = 1'b1;
                dec_o.alu_op = ALU_AND;
                dec_o.imm    = imm_zext;
            end
            OP_ORI: begin
                imm_form     = 1'b1;
                dec_o.alu_op = ALU_OR;
                dec_o.imm    = imm_zext;
            end
            OP_XORI: begin
                imm_form   = 1'b1;
                dec_o.unit = UNIT_XOR;
                dec_o.imm  = imm_zext;
            end
            OP_LLO: begin
                imm_form   = 1'b1;
                dec_o.unit = UNIT_LOADIMM;
                dec_o.imm  = imm_zext;
            end
            OP_LHI: begin
                imm_form   = 1'b1;
                dec_o.unit = UNIT_LOADIMM;
                dec_o.imm  = imm_zext << 16;
                dec_o.lhi  = 1'b1;
            end
            OP_TRAP: begin
                dec_o.trap    = 1'b1;
                dec_o.jtarget = instr_i[25:0];
            end
            OP_LB:  begin is_load = 1'b1; dec_o.mem_size = MEM_BYTE; end
            OP_LH:  begin is_load = 1'b1; dec_o.mem_size = MEM_HALF; end
            OP_LW:  begin is_load = 1'b1; dec_o.mem_size = MEM_WORD; end
            OP_LBU: begin
                is_load            = 1'b1;
                dec_o.mem_size     = MEM_BYTE;
                dec_o.mem_unsigned = 1'b1;
            end
            OP_LHU: begin
                is_load            = 1'b1;
                dec_o.mem_size     = MEM_HALF;
                dec_o.mem_unsigned = 1'b1;
            end
            OP_SB:  begin is_store = 1'b1; dec_o.mem_size = MEM_BYTE; end
            OP_SH:  begin is_store = 1'b1; dec_o.mem_size = MEM_HALF; end
            OP_SW:  begin is_store = 1'b1; dec_o.mem_size = MEM_WORD; end
            default: dec_o.illegal = 1'b1;
        endcase

        // Address generation for every memory op is base + sign-extended offset.
        if (is_load || is_store) begin
            dec_o.alu_op      = ALU_ADD;
            dec_o.alu_src_imm = 1'b1;
            dec_o.imm         = imm_sext;
        end
        if (is_load) begin
            dec_o.mem_read = 1'b1;
            imm_form       = 1'b1;
        end
        if (is_store) begin
            dec_o.mem_write = 1'b1;
        end
        if (imm_form) begin
            dec_o.alu_src_imm = 1'b1;
            dec_o.dest        = instr_i[20:16];
            wr_en             = 1'b1;
        end

        // $0 is hard-wired, so writes to it are dropped here (covers SLL $0 NOP).
        dec_o.reg_write = wr_en && (dec_o.dest != 5'd0);

        // Illegal and trap words must not produce any architectural side effect.
        if (dec_o.illegal || dec_o.trap) begin
            dec_o.reg_write = 1'b0;
            dec_o.mem_read  = 1'b0;
            dec_o.mem_write = 1'b0;
            dec_o.jump      = 1'b0;
            dec_o.jump_reg  = 1'b0;
            dec_o.link      = 1'b0;
            dec_o.br_cond   = BR_NONE;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode pipeline stage. Decodes the incoming word combinationally
// and registers the result; a second (skid) register absorbs one extra
// instruction so in_ready depends only on local state, never on out_ready.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : decode_stage_if.slave (flush, in_* handshake, out_* handshake)
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  bus
);

    decoded_type dec_w;
    decoded_type main_q, main_d;
    decoded_type skid_q, skid_d;
    logic        main_valid_q, main_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic        accept;
    logic        main_free;

    instr_decode_logic u_decode (
        .instr_i (bus.in_instr),
        .pc_i    (bus.in_pc),
        .dec_o   (dec_w)
    );

    assign accept    = bus.in_valid && !skid_valid_q;
    assign main_free = !main_valid_q || bus.out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            // An occupied skid is older than anything upstream (and upstream is
            // stalled while it is occupied), so it refills main first.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = dec_w;
                end
            end
        end else if (accept) begin
            skid_d       = dec_w;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.in_ready  = !skid_valid_q;
    assign bus.out_valid = main_valid_q;
    assign bus.out_dec   = main_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    decoded_type      exp_q[$];
    int               checks   = 0;
    int               failures = 0;
    int               n_out    = 0;
    int               cyc      = 0;
    logic [WIDTH-1:0] pc_next;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_dec(input string tag, input decoded_type got, input decoded_type exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Raw pass-through fields only; semantic fields are filled per step.
    function automatic decoded_type base(input logic [31:0] ins);
        decoded_type e;
        e       = '0;
        e.pc    = pc_next;
        e.rs    = ins[25:21];
        e.rt    = ins[20:16];
        e.shamt = ins[10:6];
        e.funct = ins[5:0];
        pc_next = pc_next + 32'd4;
        return e;
    endfunction

    // Present one instruction and hold it until accepted; expected result is
    // queued on the accepting edge. Called at posedge+1 for back-to-back issue.
    task automatic drive(input logic [31:0] ins, input decoded_type e);
        int n;
        n            = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_pc    = e.pc;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk_bit("in_ready_wait", bus.in_ready, 1'b1);
        if (bus.in_ready === 1'b1) begin
            @(posedge clk);
            exp_q.push_back(e);
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk_word("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted output must match the oldest expectation.
    always @(negedge clk) begin
        decoded_type e;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL out_unexpected got=%h exp=none", bus.out_dec);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_out++;
                checks++;
                assert (bus.out_dec === e) else begin
                    failures++;
                    $error("FAIL out_dec#%0d got=%h exp=%h", n_out, bus.out_dec, e);
                end
            end
        end
    end

    initial begin
        decoded_type e, ea, eb, ec, ed;
        logic [31:0] ins;
        int          c0;
        int          n0;

        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b1;
        pc_next       = 32'h0000_1000;
        #1;
        chk_bit("rst_out_valid", bus.out_valid, 1'b0);
        chk_bit("rst_in_ready", bus.in_ready, 1'b1);
        chk_dec("rst_out_dec", bus.out_dec, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADDI $8,$0,-1 with one-cycle latency
        ins = 32'h2008FFFF; e = base(ins);
        e.dest = 5'd8; e.imm = 32'hFFFF_FFFF; e.alu_op = ALU_ADD;
        e.alu_src_imm = 1'b1; e.reg_write = 1'b1;
        drive(ins, e);
        @(negedge clk);
        chk_bit("lat_out_valid", bus.out_valid, 1'b1);
        chk_dec("lat_addi", bus.out_dec, e);
        @(posedge clk);
        #1;

        // Back-to-back stream with out_ready=1
        c0 = cyc;
        ins = 32'h34098000; e = base(ins);
        e.dest = 5'd9; e.imm = 32'h0000_8000; e.alu_op = ALU_OR;
        e.alu_src_imm = 1'b1; e.reg_write = 1'b1;
        drive(ins, e);
        ins = 32'h8D0A0004; e = base(ins);
        e.dest = 5'd10; e.imm = 32'd4; e.alu_op = ALU_ADD; e.alu_src_imm = 1'b1;
        e.reg_write = 1'b1; e.mem_read = 1'b1; e.mem_size = MEM_WORD;
        drive(ins, e);
        ins = 32'h0C000010; e = base(ins);
        e.jump = 1'b1; e.link = 1'b1; e.dest = REG_RA; e.reg_write = 1'b1;
        e.jtarget = 26'h10;
        drive(ins, e);
        ins = 32'h03E00008; e = base(ins);
        e.jump_reg = 1'b1;
        drive(ins, e);
        ins = 32'hAD0A0008; e = base(ins);
        e.imm = 32'd8; e.alu_op = ALU_ADD; e.alu_src_imm = 1'b1;
        e.mem_write = 1'b1; e.mem_size = MEM_WORD;
        drive(ins, e);
        ins = 32'h1109FFFE; e = base(ins);
        e.imm = 32'hFFFF_FFFE; e.alu_op = ALU_SUB; e.br_cond = BR_EQ;
        drive(ins, e);
        ins = 32'h640A1234; e = base(ins);
        e.dest = 5'd10; e.imm = 32'h1234_0000; e.unit = UNIT_LOADIMM;
        e.alu_src_imm = 1'b1; e.reg_write = 1'b1; e.lhi = 1'b1;
        drive(ins, e);
        ins = 32'h910B00FF; e = base(ins);
        e.dest = 5'd11; e.imm = 32'h0000_00FF; e.alu_op = ALU_ADD; e.alu_src_imm = 1'b1;
        e.reg_write = 1'b1; e.mem_read = 1'b1; e.mem_size = MEM_BYTE; e.mem_unsigned = 1'b1;
        drive(ins, e);
        ins = 32'h01095020; e = base(ins);
        e.dest = 5'd10; e.alu_op = ALU_ADD; e.reg_write = 1'b1;
        drive(ins, e);
        ins = 32'h00094080; e = base(ins);
        e.dest = 5'd8; e.unit = UNIT_SHIFT; e.reg_write = 1'b1;
        drive(ins, e);
        ins = 32'h00000000; e = base(ins);
        e.unit = UNIT_SHIFT;
        drive(ins, e);
        ins = 32'h01095026; e = base(ins);
        e.dest = 5'd10; e.unit = UNIT_XOR; e.reg_write = 1'b1;
        drive(ins, e);
        ins = 32'h01090018; e = base(ins);
        e.unit = UNIT_MULDIV;
        drive(ins, e);
        chk_word("throughput_cycles", cyc - c0, 13);

        // Illegal opcode, illegal funct, TRAP
        ins = 32'hFC000000; e = base(ins);
        e.illegal = 1'b1;
        drive(ins, e);
        ins = 32'h0000003F; e = base(ins);
        e.illegal = 1'b1;
        drive(ins, e);
        ins = 32'h68000005; e = base(ins);
        e.trap = 1'b1; e.jtarget = 26'd5;
        drive(ins, e);
        drain();

        // Skid: out_ready=0, A into main, B into skid, C stalled
        ea = base(32'h20010001);
        ea.dest = 5'd1; ea.imm = 32'd1; ea.alu_op = ALU_ADD;
        ea.alu_src_imm = 1'b1; ea.reg_write = 1'b1;
        eb = base(32'h34020002);
        eb.dest = 5'd2; eb.imm = 32'd2; eb.alu_op = ALU_OR;
        eb.alu_src_imm = 1'b1; eb.reg_write = 1'b1;
        ec = base(32'h00221820);
        ec.dest = 5'd3; ec.alu_op = ALU_ADD; ec.reg_write = 1'b1;
        bus.out_ready = 1'b0;
        n0 = n_out;
        drive(32'h20010001, ea);
        drive(32'h34020002, eb);
        @(negedge clk);
        chk_bit("skid_out_valid", bus.out_valid, 1'b1);
        chk_bit("skid_in_ready", bus.in_ready, 1'b0);
        chk_dec("skid_main_holds_a", bus.out_dec, ea);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00221820;
        bus.in_pc    = ec.pc;
        repeat (2) @(negedge clk);
        chk_bit("skid_c_stalled", bus.in_ready, 1'b0);
        chk_dec("skid_main_still_a", bus.out_dec, ea);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drive(32'h00221820, ec);
        drain();
        chk_word("skid_out_count", n_out - n0, 3);

        // Flush with main and skid full
        bus.out_ready = 1'b0;
        drive(32'h20010001, ea);
        drive(32'h34020002, eb);
        @(negedge clk);
        chk_bit("flush_pre_in_ready", bus.in_ready, 1'b0);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00221820;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_bit("flush_out_valid", bus.out_valid, 1'b0);
        chk_bit("flush_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        ed = base(32'h2824FFF6);
        ed.dest = 5'd4; ed.imm = 32'hFFFF_FFF6; ed.alu_op = ALU_SLT;
        ed.alu_src_imm = 1'b1; ed.reg_write = 1'b1;
        drive(32'h2824FFF6, ed);
        drain();

        // Flush discards a same-cycle transfer into an empty stage
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h20010001;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk_bit("flush_discard_in", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Async reset mid-transfer
        bus.out_ready = 1'b0;
        drive(32'h20010001, ea);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h34020002;
        #2 rst_n = 1'b0;
        #1;
        chk_bit("arst_out_valid", bus.out_valid, 1'b0);
        chk_bit("arst_in_ready", bus.in_ready, 1'b1);
        chk_dec("arst_out_dec", bus.out_dec, '0);
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        ed.pc = pc_next;
        pc_next = pc_next + 32'd4;
        drive(32'h2824FFF6, ed);
        drain();

        chk_word("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
